// File: rtl/ureg_file.sv
// Universal register file: bus-connect and compute-unit write ports, two
// write-through combinational operand ports and one registered bus read port.
module ureg_file #(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int NREG = 16
) (
  input  logic          clk_dcd,
  input  logic          rst,
  input  logic [DW-1:0] bc_dt,
  input  logic          ps_rf_bcwr_en,
  input  logic [AW-1:0] ps_rf_bcwr_addr,
  input  logic          cu_rf_wr_en,
  input  logic [AW-1:0] cu_rf_wr_addr,
  input  logic [DW-1:0] cu_rf_wr_dt,
  input  logic [AW-1:0] ps_rf_rda_addr,
  input  logic [AW-1:0] ps_rf_rdb_addr,
  output logic [DW-1:0] rf_cu_dta,
  output logic [DW-1:0] rf_cu_dtb,
  input  logic          ps_rf_rdx_en,
  input  logic [AW-1:0] ps_rf_rdx_addr,
  output logic [DW-1:0] rf_bc_dt,
  output logic          rf_wr_cflct
);

  logic [DW-1:0] mem     [NREG];
  logic [DW-1:0] eff_arr [NREG];
  logic [DW-1:0] rdx_val;
  logic          cflct_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  // Effective next value of every register; the compute unit overrides the bus.
  // NOTE: each element gets its default (the stored value) before any
  // conditional override, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      eff_arr[i] = mem[i];
      if (ps_rf_bcwr_en && ps_rf_bcwr_addr == AW'(i)) eff_arr[i] = bc_dt;
      if (cu_rf_wr_en && cu_rf_wr_addr == AW'(i))     eff_arr[i] = cu_rf_wr_dt;
    end
  end

  assign rf_cu_dta = in_range(ps_rf_rda_addr) ? eff_arr[ps_rf_rda_addr] : '0;
  assign rf_cu_dtb = in_range(ps_rf_rdb_addr) ? eff_arr[ps_rf_rdb_addr] : '0;
  assign rdx_val   = in_range(ps_rf_rdx_addr) ? eff_arr[ps_rf_rdx_addr] : '0;

  assign cflct_d = cu_rf_wr_en && ps_rf_bcwr_en &&
                   (cu_rf_wr_addr == ps_rf_bcwr_addr) && in_range(cu_rf_wr_addr);

  // NOTE: the array is reset explicitly because software expects every
  // register to read 0 after reset; this keeps it in flops, not a RAM macro.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_dcd) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      rf_bc_dt    <= '0;
      rf_wr_cflct <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) mem[i] <= eff_arr[i];
      if (ps_rf_rdx_en) rf_bc_dt <= rdx_val;
      rf_wr_cflct <= cflct_d;
    end
  end

endmodule

// File: tb/tb_ureg_file.sv
// Directed bench for ureg_file: stimulus pushes expectations tagged with the
// cycle they are due in; a negedge monitor compares and retires them.
module tb_ureg_file;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk_dcd = 1'b0;
  logic          rst;
  logic [DW-1:0] bc_dt;
  logic          ps_rf_bcwr_en;
  logic [AW-1:0] ps_rf_bcwr_addr;
  logic          cu_rf_wr_en;
  logic [AW-1:0] cu_rf_wr_addr;
  logic [DW-1:0] cu_rf_wr_dt;
  logic [AW-1:0] ps_rf_rda_addr;
  logic [AW-1:0] ps_rf_rdb_addr;
  logic [DW-1:0] rf_cu_dta;
  logic [DW-1:0] rf_cu_dtb;
  logic          ps_rf_rdx_en;
  logic [AW-1:0] ps_rf_rdx_addr;
  logic [DW-1:0] rf_bc_dt;
  logic          rf_wr_cflct;

  ureg_file #(.DW(DW), .AW(AW), .NREG(16)) dut (
    .clk_dcd         (clk_dcd),
    .rst             (rst),
    .bc_dt           (bc_dt),
    .ps_rf_bcwr_en   (ps_rf_bcwr_en),
    .ps_rf_bcwr_addr (ps_rf_bcwr_addr),
    .cu_rf_wr_en     (cu_rf_wr_en),
    .cu_rf_wr_addr   (cu_rf_wr_addr),
    .cu_rf_wr_dt     (cu_rf_wr_dt),
    .ps_rf_rda_addr  (ps_rf_rda_addr),
    .ps_rf_rdb_addr  (ps_rf_rdb_addr),
    .rf_cu_dta       (rf_cu_dta),
    .rf_cu_dtb       (rf_cu_dtb),
    .ps_rf_rdx_en    (ps_rf_rdx_en),
    .ps_rf_rdx_addr  (ps_rf_rdx_addr),
    .rf_bc_dt        (rf_bc_dt),
    .rf_wr_cflct     (rf_wr_cflct)
  );

  always #5 clk_dcd = ~clk_dcd;

  typedef enum int { SEL_DTA, SEL_DTB, SEL_BCDT, SEL_CFLCT } sel_e;
  typedef struct {
    int            cyc;
    sel_e          sel;
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk_dcd) cyc <= cyc + 1;

  task automatic expect_now(input sel_e sel, input logic [DW-1:0] exp, input string name);
    sb.push_back('{cyc, sel, exp, name});
  endtask

  task automatic expect_next(input sel_e sel, input logic [DW-1:0] exp, input string name);
    sb.push_back('{cyc + 1, sel, exp, name});
  endtask

  function automatic logic [DW-1:0] pick(input sel_e sel);
    case (sel)
      SEL_DTA:  return rf_cu_dta;
      SEL_DTB:  return rf_cu_dtb;
      SEL_BCDT: return rf_bc_dt;
      default:  return {{(DW-1){1'b0}}, rf_wr_cflct};
    endcase
  endfunction

  // Monitor: retire every expectation due in the current cycle.
  always @(negedge clk_dcd) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [DW-1:0] got;
        got = pick(sb[i].sel);
        vectors++;
        if (got !== sb[i].exp) begin
          miscompares++;
          $display("FAIL %s (cycle %0d): got %h expected %h", sb[i].name, cyc, got, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  // Advance to just after the next edge, then drive one cycle of stimulus.
  task automatic drive(input logic r,
                       input logic cu_en, input logic [AW-1:0] cu_a, input logic [DW-1:0] cu_d,
                       input logic bc_en, input logic [AW-1:0] bc_a, input logic [DW-1:0] bc_d,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic rx_en, input logic [AW-1:0] rx_a);
    @(posedge clk_dcd);
    #1;
    rst = r;
    cu_rf_wr_en = cu_en; cu_rf_wr_addr = cu_a; cu_rf_wr_dt = cu_d;
    ps_rf_bcwr_en = bc_en; ps_rf_bcwr_addr = bc_a; bc_dt = bc_d;
    ps_rf_rda_addr = ra; ps_rf_rdb_addr = rb;
    ps_rf_rdx_en = rx_en; ps_rf_rdx_addr = rx_a;
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ra, rb, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    cu_rf_wr_en = 1'b0; cu_rf_wr_addr = '0; cu_rf_wr_dt = '0;
    ps_rf_bcwr_en = 1'b0; ps_rf_bcwr_addr = '0; bc_dt = '0;
    ps_rf_rda_addr = '0; ps_rf_rdb_addr = '0;
    ps_rf_rdx_en = 1'b0; ps_rf_rdx_addr = '0;
    repeat (2) @(posedge clk_dcd);

    // 1. Writes (last one a conflict) then a reset cycle that also requests writes and a read.
    drive(1'b0, 1'b1, 4'd2, 16'h1357, 1'b1, 4'd9, 16'h2468, 4'd0, 4'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd3, 16'h5678, 1'b1, 4'd3, 16'h1234, 4'd0, 4'd0, 1'b1, 4'd9);
    drive(1'b1, 1'b1, 4'd9, 16'hAAAA, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b1, 4'd3);
    expect_next(SEL_BCDT, 16'h0000, "reset_bc_dt");
    expect_next(SEL_CFLCT, 16'h0000, "reset_cflct");
    for (int k = 0; k < 8; k++) begin
      idle(AW'(2 * k), AW'(2 * k + 1));
      expect_now(SEL_DTA, 16'h0000, $sformatf("reset_r%0d", 2 * k));
      expect_now(SEL_DTB, 16'h0000, $sformatf("reset_r%0d", 2 * k + 1));
    end

    // 2. Bus write then read on the next cycle.
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'hA5A5, 4'd0, 4'd0, 1'b0, 4'd0);
    expect_next(SEL_CFLCT, 16'h0000, "bus_only_no_cflct");
    idle(4'd3, 4'd0);
    expect_now(SEL_DTA, 16'hA5A5, "bus_write_r3");

    // 3. Same-cycle write-through on operand A, stored value on operand B.
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h1111, 4'd5, 4'd3, 1'b0, 4'd0);
    expect_now(SEL_DTA, 16'h1111, "write_through_r5");
    expect_now(SEL_DTB, 16'hA5A5, "stored_r3");

    // 4. Both writers on r7: compute unit wins, conflict pulses for one cycle.
    drive(1'b0, 1'b1, 4'd7, 16'h00FF, 1'b1, 4'd7, 16'hFF00, 4'd7, 4'd5, 1'b0, 4'd0);
    expect_now(SEL_DTA, 16'h00FF, "conflict_wt_r7");
    expect_next(SEL_CFLCT, 16'h0001, "conflict_pulse");
    idle(4'd7, 4'd5);
    expect_now(SEL_DTA, 16'h00FF, "conflict_stored_r7");
    expect_now(SEL_DTB, 16'h1111, "stored_r5");
    expect_next(SEL_CFLCT, 16'h0000, "conflict_cleared");

    // 5. Both writers on different registers.
    drive(1'b0, 1'b1, 4'd1, 16'h0001, 1'b1, 4'd2, 16'h0002, 4'd1, 4'd2, 1'b0, 4'd0);
    expect_next(SEL_CFLCT, 16'h0000, "dual_no_cflct");
    idle(4'd1, 4'd2);
    expect_now(SEL_DTA, 16'h0001, "dual_r1");
    expect_now(SEL_DTB, 16'h0002, "dual_r2");

    // 6. Registered bus read, hold when disabled, and write-through on the read path.
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'hBEEF, 4'd0, 4'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 4'd4);
    expect_next(SEL_BCDT, 16'hBEEF, "rdx_r4");
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'h0000, 4'd4, 4'd0, 1'b0, 4'd4);
    expect_next(SEL_BCDT, 16'hBEEF, "rdx_hold");
    drive(1'b0, 1'b1, 4'd8, 16'hCAFE, 1'b0, 4'd0, 16'h0, 4'd4, 4'd0, 1'b1, 4'd8);
    expect_now(SEL_DTA, 16'h0000, "r4_overwritten");
    expect_next(SEL_BCDT, 16'hCAFE, "rdx_write_through");
    idle(4'd8, 4'd0);
    expect_next(SEL_BCDT, 16'hCAFE, "rdx_hold2");

    // Back-to-back writes to one register: last one wins.
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd10, 16'h0101, 4'd0, 4'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd10, 16'h0202, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0);
    idle(4'd10, 4'd15);
    expect_now(SEL_DTA, 16'h0202, "back_to_back_r10");
    expect_now(SEL_DTB, 16'h0000, "untouched_r15");

    repeat (3) @(posedge clk_dcd);
    #1;
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
